// File: rtl/clock_set_pkg.sv
// Shared types and constants for the BCD clock time-entry front end.
package clock_set_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_TENS,
        EDIT_UNITS,
        COMMIT
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] EDIT_SEL_IDLE  = 2'b00;
    localparam logic [1:0] EDIT_SEL_TENS  = 2'b10;
    localparam logic [1:0] EDIT_SEL_UNITS = 2'b01;

    // Binary value of a two-digit BCD pair; 8 bits covers even non-BCD nibbles.
    function automatic logic [7:0] bcd_value(input bcd_t tens, input bcd_t units);
        return 8'(tens) * 8'd10 + 8'(units);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low pushbutton into a single-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized level agrees with the accepted one restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-button digit-by-digit editor for the two-digit BCD clock value; commits via a load strobe.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000,
    parameter int MAX_VALUE       = 23
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic [3:0] cur_tens,
    input  logic [3:0] cur_units,
    output logic [3:0] set_tens,
    output logic [3:0] set_units,
    output logic       load,
    output logic [1:0] edit_sel,
    output logic       blink
);

    localparam bcd_t       MAX_T = bcd_t'(MAX_VALUE / 10);
    localparam bcd_t       MAX_U = bcd_t'(MAX_VALUE % 10);
    localparam logic [7:0] MAX_V = 8'(MAX_VALUE);
    localparam int         BW    = $clog2(BLINK_CYCLES + 1);

    logic          mode_p, inc_p;
    state_e        state_q, state_d;
    bcd_t          tens_q, tens_d, units_q, units_d;
    bcd_t          next_tens, unit_lim;
    logic          load_q, load_d;
    logic          blink_q, blink_d, editing_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_mode_n), .press(mode_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_inc_n), .press(inc_p)
    );

    // Mode is tested before inc in every state so a simultaneous inc is dropped.
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        units_d   = units_q;
        load_d    = 1'b0;
        next_tens = tens_q;
        unit_lim  = (tens_q == MAX_T) ? MAX_U : 4'd9;
        case (state_q)
            IDLE: if (mode_p) begin
                state_d = EDIT_TENS;
                if (cur_tens > 4'd9 || cur_units > 4'd9 ||
                    bcd_value(cur_tens, cur_units) > MAX_V) begin
                    tens_d  = '0;
                    units_d = '0;
                end else begin
                    tens_d  = cur_tens;
                    units_d = cur_units;
                end
            end
            EDIT_TENS: if (mode_p) begin
                state_d = EDIT_UNITS;
            end else if (inc_p) begin
                next_tens = (tens_q >= MAX_T) ? '0 : tens_q + 4'd1;
                tens_d    = next_tens;
                if (bcd_value(next_tens, units_q) > MAX_V) units_d = '0;
            end
            EDIT_UNITS: if (mode_p) begin
                state_d = COMMIT;
            end else if (inc_p) begin
                units_d = (units_q >= unit_lim) ? '0 : units_q + 4'd1;
            end
            COMMIT: begin
                load_d = ~load_q;
                if (load_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink restarts high whenever a new digit comes under edit.
    always_comb begin
        editing_d = (state_d == EDIT_TENS) || (state_d == EDIT_UNITS);
        blink_d   = 1'b0;
        bcnt_d    = '0;
        if (editing_d && state_d != state_q) begin
            blink_d = 1'b1;
        end else if (editing_d) begin
            if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tens_q  <= '0;
            units_q <= '0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        case (state_q)
            EDIT_TENS:  edit_sel = EDIT_SEL_TENS;
            EDIT_UNITS: edit_sel = EDIT_SEL_UNITS;
            default:    edit_sel = EDIT_SEL_IDLE;
        endcase
    end

    assign set_tens  = tens_q;
    assign set_units = units_q;
    assign load      = load_q;
    assign blink     = blink_q;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-entry front end for the two-digit BCD clock: debounces two active-low pushbuttons and lets the user edit a tens/units BCD value digit by digit. On commit it emits a one-cycle load strobe with the new value for the sequence counter. It is the writer side of the counter/display path: the counter's live digits come in, and edited digits plus a load strobe go back out. Blink and digit-select outputs let the 7-segment path flash the digit being edited.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized key level must be stable before it is accepted (20 ms at 50 MHz); minimum 2.
- BLINK_CYCLES, 12_500_000: half-period of the blink output, in cycles.
- MAX_VALUE, 23: largest legal two-digit value; range 1..99.

Ports:
- CLOCK_50, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- key_mode_n, in, 1: raw mode button, active-low, asynchronous to CLOCK_50.
- key_inc_n, in, 1: raw increment button, active-low, asynchronous to CLOCK_50.
- cur_tens, in, 4: live tens digit from the counter (BCD).
- cur_units, in, 4: live units digit from the counter (BCD).
- set_tens, out, 4: edited tens digit (BCD).
- set_units, out, 4: edited units digit (BCD).
- load, out, 1: one-cycle commit strobe; set_tens and set_units are valid in the same cycle.
- edit_sel, out, 2: 00 = idle, 10 = editing tens, 01 = editing units.
- blink, out, 1: blink phase while editing; 0 when idle.

## Operation
- Key conditioning, per key:
  - 2-FF synchronizer.
  - Stability counter: the debounced level updates only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce resets the counter.
  - A debounced 1→0 transition produces a one-cycle press pulse.
  - Releases produce nothing.
- FSM states: IDLE, EDIT_TENS, EDIT_UNITS, COMMIT.
  - IDLE + mode press → EDIT_TENS. In that cycle, set_tens/set_units capture cur_tens/cur_units. If the captured value > MAX_VALUE, capture 0/0 instead.
  - EDIT_TENS + inc press → tens = tens+1, wrapping to 0 past MAX_VALUE/10. If the new value > MAX_VALUE, units is forced to 0 (MAX 23, value 17 → 20).
  - EDIT_TENS + mode press → EDIT_UNITS.
  - EDIT_UNITS + inc press → units = units+1. The limit is 9, or MAX_VALUE%10 when tens == MAX_VALUE/10; past the limit, units wraps to 0.
  - EDIT_UNITS + mode press → COMMIT.
  - COMMIT: load = 1 for exactly one cycle, then IDLE unconditionally. Presses arriving in COMMIT are dropped.
- Inc presses in IDLE are ignored.
- Mode and inc pressed in the same cycle: mode wins, inc is dropped.
- set_tens/set_units hold their last value in IDLE; they are never invalid BCD.
- edit_sel follows the state; COMMIT and IDLE both give 00.
- blink:
  - Forced to 1 and its counter cleared on every entry to EDIT_TENS or EDIT_UNITS.
  - Toggles every BLINK_CYCLES cycles while editing.
  - 0 in IDLE and COMMIT.

## Timing
- Reset (async assert, sync release by design): state IDLE; set_tens = set_units = 0; load = 0; edit_sel = 00; blink = 0. Debounced levels reset to 1 (released), stability counters to 0.
- Press latency: a raw key first sampled low at edge N, held stable, gives a press pulse at edge N + 2 + DEBOUNCE_CYCLES.
- State change, digit update and edit_sel update are registered: visible in the cycle after the press pulse.
- load asserts the cycle after the state becomes COMMIT. It is exactly one cycle wide, and the state returns to IDLE in the same cycle load drops.
- Reset mid-edit discards the edit; no load is issued.
- A held key produces exactly one press; auto-repeat is not supported.

## Structure
- Package clock_set_pkg:
  - state enum (IDLE, EDIT_TENS, EDIT_UNITS, COMMIT).
  - bcd_t (4-bit digit).
  - EDIT_SEL_* constants.
- Sub-module key_debounce (synchronizer, stability counter, press pulse), parameterized by DEBOUNCE_CYCLES, instantiated once per key.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, BLINK_CYCLES = 8, MAX_VALUE = 23.
- Reset: pulse reset_n low mid-edit → all outputs 0, edit_sel = 00, no load.
- Bounce rejection: toggle key_mode_n every 2 cycles for 20 cycles, then hold high → no press pulse, state stays IDLE.
- Full edit:
  - cur = 1/7, press mode → set = 1/7, edit_sel = 10.
  - Press inc → set = 2/0.
  - Press inc → set = 0/0.
  - Mode, then inc ×3 → set = 0/3.
  - Mode → load is a one-cycle pulse with 0/3, then edit_sel = 00.
- Units limit: tens = 2, inc ×4 from units 0 → units 1, 2, 3, 0.
- Simultaneous keys: both buttons released to pressed on the same edge in EDIT_TENS → state EDIT_UNITS, tens unchanged. Press pulse exactly 6 cycles after the raw edge.
- Blink: enter EDIT_TENS → blink = 1, toggles every 8 cycles; restarts at 1 on entering EDIT_UNITS; 0 after commit.
